// File: rtl/data_mem_responder.sv
// Data-memory responder: single-outstanding load/store port in front of an on-chip word array.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns any non-word-aligned access into an error response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_error_q, resp_error_d;

  logic [31:0]        mem [DEPTH_WORDS];

  // Request decode: offset from the array base, range and alignment checks.
  logic [31:0]        req_off;
  logic               req_in_range;
  logic               req_misalign;
  logic               req_err;
  logic [IDX_W-1:0]   req_idx;
  logic               addr_lsb_unused;
  logic               accept;
  logic               mem_we;

  assign req_off      = req_addr - BASE_ADDR;
  assign req_in_range = (req_addr >= BASE_ADDR) && ({2'b00, req_off[31:2]} < 32'(DEPTH_WORDS));
  assign req_idx      = req_off[IDX_W+1:2];
  assign addr_lsb_unused = ^req_off[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misalign = |req_addr[1:0];
`else
  assign req_misalign = 1'b0;
`endif

  assign req_err   = !req_in_range || req_misalign;
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  // Stores commit at the accept edge; reset blocks a write while the FSM is held idle.
  assign mem_we    = accept && req_write && !req_err && rst_n;

  // With a single-cycle latency the response is formed straight from the live request.
  logic               cur_write;
  logic               cur_err;
  logic [IDX_W-1:0]   cur_idx;

  assign cur_write = (state_q == S_IDLE) ? req_write : write_q;
  assign cur_err   = (state_q == S_IDLE) ? req_err   : err_q;
  assign cur_idx   = (state_q == S_IDLE) ? req_idx   : idx_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    err_d        = err_q;
    idx_d        = idx_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          err_d   = req_err;
          idx_d   = req_idx;
          if (LATENCY > 1) begin
            state_d = S_BUSY;
            cnt_d   = BUSY_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load data is captured on the edge that enters RESP, after all earlier stores landed.
    if (state_q != S_RESP && state_d == S_RESP) begin
      resp_valid_d = 1'b1;
      resp_error_d = cur_err;
      resp_rdata_d = (!cur_write && !cur_err) ? mem[cur_idx] : '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // NOTE: the array has no reset so it maps onto SRAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized traffic
// compared every cycle against a transaction-level model (honours DMEM_MISALIGN_TRAP_EN).
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: word array, one pending response and the edge it becomes visible.
  logic [31:0] m_mem [DEPTH];
  bit          m_pend = 1'b0;
  longint      m_edge = 0;
  longint      m_rise = 0;
  logic [31:0] m_rdata;
  logic        m_err;
  bit          mon_en = 1'b0;

  function automatic bit m_ok(input logic [31:0] a);
    longint unsigned ua;
    ua = a;
    if (ua < longint'(BASE)) return 1'b0;
    if ((ua - longint'(BASE)) / 4 >= longint'(DEPTH)) return 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) return 1'b0;
`endif
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = 1'b0;
      end else begin
        m_edge++;
        if (m_pend) begin
          if (m_edge - 1 >= m_rise && resp_ready) m_pend = 1'b0;
        end else if (req_valid) begin
          int idx;
          bit ok;
          ok  = m_ok(req_addr);
          idx = int'((req_addr - BASE) >> 2);
          if (ok && req_write) begin
            for (int i = 0; i < 4; i++)
              if (req_wstrb[i]) m_mem[idx][8*i +: 8] = req_wdata[8*i +: 8];
          end
          m_err   = !ok;
          m_rdata = (ok && !req_write) ? m_mem[idx] : 32'h0;
          m_pend  = 1'b1;
          m_rise  = m_edge + LAT - 1;
        end
      end
    end
  end

  // One compare process: every negedge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic exp_valid;
        exp_valid = m_pend && (m_edge >= m_rise);
        check("mon_resp_valid", 32'(resp_valid), 32'(exp_valid));
        check("mon_req_ready", 32'(req_ready), 32'(!m_pend));
        check("mon_resp_rdata", resp_rdata, exp_valid ? m_rdata : 32'h0);
        check("mon_resp_error", 32'(resp_error), exp_valid ? 32'(m_err) : 32'h0);
      end
    end
  end

  // Issue one request from a negedge, optionally stall the response, return what was seen.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int stall,
                        output logic [31:0] rd, output logic er);
    int n;
    int lat;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b for %0d cycles", req_ready, n);
    end
    @(negedge clk);
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(LAT));
    rd = resp_rdata;
    er = resp_error;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'h0);
      check("stall_resp_rdata", resp_rdata, rd);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("ready_after_resp", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] last_addr;
    logic [31:0] oor_addr;
    int          cnt;

    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_wstrb  = 4'h0;
    resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_error", 32'(resp_error), 32'h0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Give every word a known value so the model covers the whole array.
    for (int i = 0; i < int'(DEPTH); i++)
      do_req(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, rd, er);

    // Store then load back.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    check("t2_store_err", 32'(er), 32'h0);
    check("t2_store_rdata", rd, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("t2_load_rdata", rd, 32'hDEADBEEF);
    check("t2_load_err", 32'(er), 32'h0);

    // Byte-lane merge, then a zero-strobe store that must change nothing.
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h20, 32'h0000AB00, 4'b0010, 0, rd, er);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    check("t3_lane_merge", rd, 32'h1122AB44);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er);
    check("t3_nostrobe_err", 32'(er), 32'h0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    check("t3_nostrobe_keep", rd, 32'h1122AB44);

    // Back-pressure on the response for five cycles.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    check("t4_stall_rdata", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    check("t4_next_rdata", rd, 32'h1122AB44);

    // One word past the top of the array.
    last_addr = BASE + 32'(4 * (DEPTH - 1));
    oor_addr  = BASE + 32'(4 * DEPTH);
    do_req(1'b1, last_addr, 32'h5A5A5A5A, 4'hF, 0, rd, er);
    do_req(1'b1, oor_addr, 32'hFFFFFFFF, 4'hF, 0, rd, er);
    check("t5_oor_store_err", 32'(er), 32'h1);
    check("t5_oor_store_rdata", rd, 32'h0);
    do_req(1'b0, oor_addr, 32'h0, 4'h0, 0, rd, er);
    check("t5_oor_load_err", 32'(er), 32'h1);
    check("t5_oor_load_rdata", rd, 32'h0);
    do_req(1'b0, last_addr, 32'h0, 4'h0, 0, rd, er);
    check("t5_last_word", rd, 32'h5A5A5A5A);

    // Misaligned store.
    do_req(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t6_misalign_word", rd, 32'hDEADBEEF);
`else
    check("t6_aligned_down_word", rd, 32'hCAFEF00D);
`endif

    // Reset while a load is in BUSY.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_wstrb = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("t1_rst_req_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("t1_abandoned_resp", 32'(cnt), 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t1_mem_survives_reset", rd, 32'hDEADBEEF);
`else
    check("t1_mem_survives_reset", rd, 32'hCAFEF00D);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        1:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        2:       a = BASE + 32'(4 * DEPTH) - 32'd8 + 32'($urandom_range(0, 15));
        3:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
